// File: rtl/es_dsc_mul_nway.sv
// es_dsc_mul_nway
//
// Stochastic (unary-stream) multiplier for NUM_INPUTS unsigned operands.
// Each operand x_i becomes a unary bit stream s_i = (cnt_i < x_i). The
// counters form a mixed-radix odometer: cnt_0 steps every RUN cycle, and
// cnt_i steps only when cnt_0..cnt_{i-1} are all at max. Over the 2^L RUN
// cycles (L = OUT_WIDTH) every counter combination appears exactly once.
// The number of cycles where all s_i are high is therefore the exact
// product of the operands.
//
// Parameters:
//   DATA_WIDTH   operand width (default 5)
//   NUM_INPUTS   operand count, 1..4 (default 2)
//   OUT_WIDTH    derived, DATA_WIDTH*NUM_INPUTS
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   en            start request, accepted in IDLE or DONE
//   bin_data_in   operands, packed [NUM_INPUTS-1:0][DATA_WIDTH-1:0]
//   bin_data_out  registered product, held until the next DONE or reset
//   busy          high in RUN
//   done          one-cycle pulse in DONE, bin_data_out valid
//
// Configuration macro:
//   ES_ZERO_SKIP_EN  when defined, a start with any zero operand goes
//                    straight to DONE with a zero result and no RUN phase.

module es_dsc_mul_nway #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  localparam int OUT_WIDTH = DATA_WIDTH * NUM_INPUTS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in,
  output logic [OUT_WIDTH-1:0]                  bin_data_out,
  output logic                                  busy,
  output logic                                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                                state, state_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_q;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] cnt_q;
  logic [OUT_WIDTH-1:0]                  acc_q;

  logic [NUM_INPUTS:0]  carry;     // carry[i]: cnt_0..cnt_{i-1} all at max
  logic                 all_max;   // last RUN cycle
  logic                 stream_and;
  logic [OUT_WIDTH-1:0] acc_next;
  logic                 start;

  assign start = en && (state == IDLE || state == DONE);

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    carry      = '0;
    carry[0]   = 1'b1;
    stream_and = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      carry[i+1] = carry[i] && (cnt_q[i] == {DATA_WIDTH{1'b1}});
      stream_and = stream_and && (cnt_q[i] < x_q[i]);
    end
    all_max  = carry[NUM_INPUTS];
    acc_next = acc_q + OUT_WIDTH'(stream_and);
  end

`ifdef ES_ZERO_SKIP_EN
  logic any_zero;
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bin_data_in[i] == '0) any_zero = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: begin
        if (en) begin
          state_d = RUN;
`ifdef ES_ZERO_SKIP_EN
          if (any_zero) state_d = DONE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN:     if (all_max) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand and counter arrays are a handful of flops, not a
      // memory, so they are reset along with the rest of the datapath.
      state        <= IDLE;
      x_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      bin_data_out <= '0;
    end else begin
      state <= state_d;
      if (start) begin
        x_q   <= bin_data_in;
        cnt_q <= '0;
        acc_q <= '0;
`ifdef ES_ZERO_SKIP_EN
        if (any_zero) bin_data_out <= '0;
`endif
      end else if (state == RUN) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          cnt_q[i] <= cnt_q[i] + DATA_WIDTH'(carry[i]);
        end
        acc_q <= acc_next;
        // Final cycle: include this cycle's stream bit in the result.
        if (all_max) bin_data_out <= acc_next;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_es_dsc_mul_nway.sv
// Directed testbench for es_dsc_mul_nway.
// Instance u_dut: DATA_WIDTH=3, NUM_INPUTS=2. Instance u_wide: DATA_WIDTH=2,
// NUM_INPUTS=3. Inputs are driven and outputs sampled 1 time unit after
// each rising edge. Cycle 1 is the cycle following the accepted start edge.

module tb_es_dsc_mul_nway;

  logic            clk;
  logic            rst;
  logic            en;
  logic [1:0][2:0] din;
  logic [5:0]      dout;
  logic            busy;
  logic            done;

  logic            en2;
  logic [2:0][1:0] din2;
  logic [5:0]      dout2;
  logic            busy2;
  logic            done2;

  int n_cmp = 0;
  int n_bad = 0;

  es_dsc_mul_nway #(.DATA_WIDTH(3), .NUM_INPUTS(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .bin_data_in(din),
    .bin_data_out(dout), .busy(busy), .done(done)
  );

  es_dsc_mul_nway #(.DATA_WIDTH(2), .NUM_INPUTS(3)) u_wide (
    .clk(clk), .rst(rst), .en(en2), .bin_data_in(din2),
    .bin_data_out(dout2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts u_dut with operands a,b and waits for done. Returns the cycle
  // index at which done was seen and the number of busy cycles before it.
  task automatic start_wait(input logic [2:0] a, input logic [2:0] b,
                            input bit hold_en, output int lat, output int busy_n);
    en     = 1'b1;
    din[0] = a;
    din[1] = b;
    step();
    if (!hold_en) en = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_n++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    en2 = 1'b0;
    din = '0;
    din2 = '0;
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (dout !== 6'd0) begin n_bad++; $display("FAIL reset_out: got %0d want 0", dout); end
    n_cmp++; if (dout2 !== 6'd0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_bad++; $display("FAIL reset_wide: out %0d busy %b done %b want 0 0 0", dout2, busy2, done2);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [2:0] va [4] = '{3'd5, 3'd1, 3'd7, 3'd3};
    logic [2:0] vb [4] = '{3'd6, 3'd1, 3'd1, 3'd4};
    logic [5:0] vp [4] = '{6'd30, 6'd1, 6'd7, 6'd12};
    int lat, bn;
    for (int i = 0; i < 4; i++) begin
      start_wait(va[i], vb[i], 1'b0, lat, bn);
      n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL basic_lat[%0d]: got %0d want 65", i, lat); end
      n_cmp++; if (bn !== 64) begin n_bad++; $display("FAIL basic_busy[%0d]: got %0d want 64", i, bn); end
      n_cmp++; if (dout !== vp[i]) begin n_bad++; $display("FAIL basic_out[%0d]: got %0d want %0d", i, dout, vp[i]); end
    end
    // DONE with en low returns to IDLE; the result is held.
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_pulse: done %b busy %b want 0 0", done, busy);
    end
    repeat (3) step();
    n_cmp++; if (dout !== 6'd12) begin n_bad++; $display("FAIL basic_hold: got %0d want 12", dout); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, k;
    start_wait(3'd7, 3'd7, 1'b1, lat, bn);
    n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL b2b_lat1: got %0d want 65", lat); end
    n_cmp++; if (dout !== 6'd49) begin n_bad++; $display("FAIL b2b_out1: got %0d want 49", dout); end
    din[0] = 3'd3;
    din[1] = 3'd2;
    step();
    en = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    n_cmp++; if (k !== 65) begin n_bad++; $display("FAIL b2b_lat2: got %0d want 65", k); end
    n_cmp++; if (dout !== 6'd6) begin n_bad++; $display("FAIL b2b_out2: got %0d want 6", dout); end
    step();
  endtask

  task automatic test_zero();
    int lat, bn;
    start_wait(3'd0, 3'd5, 1'b0, lat, bn);
`ifdef ES_ZERO_SKIP_EN
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_lat: got %0d want 1", lat); end
    n_cmp++; if (bn !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", bn); end
`else
    n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL zero_lat: got %0d want 65", lat); end
    n_cmp++; if (bn !== 64) begin n_bad++; $display("FAIL zero_busy: got %0d want 64", bn); end
`endif
    n_cmp++; if (dout !== 6'd0) begin n_bad++; $display("FAIL zero_out: got %0d want 0", dout); end
    step();
  endtask

  task automatic test_ignore_en();
    int k, dones, lat;
    en     = 1'b1;
    din[0] = 3'd4;
    din[1] = 3'd4;
    step();
    en    = 1'b0;
    k     = 1;
    dones = 0;
    lat   = 0;
    while (k < 75) begin
      if (k == 10) begin
        en     = 1'b1;
        din[0] = 3'd1;
        din[1] = 3'd1;
      end else begin
        en = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (lat == 0) lat = k;
        n_cmp++; if (dout !== 6'd16) begin n_bad++; $display("FAIL ign_out: got %0d want 16", dout); end
      end
      step();
      k++;
    end
    n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL ign_lat: got %0d want 65", lat); end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ign_dones: got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    en     = 1'b1;
    din[0] = 3'd6;
    din[1] = 3'd5;
    step();
    en = 1'b0;
    repeat (19) step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rrun_busy_before: got %b want 1", busy); end
    // Reset and start request together: reset wins.
    rst = 1'b1;
    en  = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rrun_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rrun_done: got %b want 0", done); end
    n_cmp++; if (dout !== 6'd0) begin n_bad++; $display("FAIL rrun_out: got %0d want 0", dout); end
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      step();
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rrun_no_done: got %0d active cycles want 0", dones); end
  endtask

  task automatic test_wide();
    int k;
    en2     = 1'b1;
    din2[0] = 2'd3;
    din2[1] = 2'd3;
    din2[2] = 2'd2;
    step();
    en2 = 1'b0;
    k = 1;
    while (done2 !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    n_cmp++; if (k !== 65) begin n_bad++; $display("FAIL wide_lat: got %0d want 65", k); end
    n_cmp++; if (dout2 !== 6'd18) begin n_bad++; $display("FAIL wide_out: got %0d want 18", dout2); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_ignore_en();
    test_reset_mid_run();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
